// File: rtl/sw_pass_scheduler_pkg.sv
// Shared defaults and state encoding for the multi-pass Smith-Waterman scheduler.
package sw_pass_scheduler_pkg;

  localparam int unsigned PE_N_DEF    = 64;
  localparam int unsigned LEN_W_DEF   = 16;
  localparam int unsigned SCORE_W_DEF = 16;
  localparam int unsigned PE_N_LOG    = $clog2(PE_N_DEF);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_RUN   = 3'd2,
    S_ACC   = 3'd3,
    S_DONE  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/sw_pass_scheduler_if.sv
// Pass command / completion channel between the scheduler and the PE array controller.
interface sw_pass_scheduler_if
  import sw_pass_scheduler_pkg::*;
#(
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned SCORE_W = SCORE_W_DEF
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [LEN_W-1:0]   cmd_s_base;
  logic [LEN_W-1:0]   cmd_s_cnt;
  logic [LEN_W-1:0]   cmd_t_len;
  logic               cmd_first;
  logic               cmd_last;
  logic               pass_done;
  logic [SCORE_W-1:0] pass_score;

  modport master (
    output cmd_valid, cmd_s_base, cmd_s_cnt, cmd_t_len, cmd_first, cmd_last,
    input  cmd_ready, pass_done, pass_score
  );

  modport slave (
    input  cmd_valid, cmd_s_base, cmd_s_cnt, cmd_t_len, cmd_first, cmd_last,
    output cmd_ready, pass_done, pass_score
  );

endinterface

// File: rtl/sw_pass_scheduler_max.sv
// Running unsigned maximum register with synchronous clear and load enable.
module sw_score_max_reg #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (load && (d > q)) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sw_pass_scheduler.sv
// Splits the query into PE_N-sized segments, issues one pass command per segment
// and tracks the best pass score of the run.
module sw_pass_scheduler
  import sw_pass_scheduler_pkg::*;
#(
  parameter int unsigned PE_N    = PE_N_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned SCORE_W = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [LEN_W-1:0]   i_s_len,
  input  logic [LEN_W-1:0]   i_t_len,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [SCORE_W-1:0] o_best_score,
  output logic               o_best_valid,
  output logic [LEN_W-1:0]   o_pass_idx,
  sw_pass_scheduler_if.master cmd
);

  localparam logic [LEN_W-1:0] SEG_MAX   = LEN_W'(PE_N);
  localparam logic [LEN_W:0]   BASE_STEP = (LEN_W+1)'(PE_N);

  sched_state_t       state, state_n;
  logic [LEN_W-1:0]   rem_q, rem_n;
  logic [LEN_W:0]     base_q, base_n;
  logic [LEN_W-1:0]   idx_q, idx_n;
  logic [LEN_W-1:0]   t_len_q, t_len_n;
  logic               err_q, err_n;
  logic               valid_q, valid_n;
  logic [SCORE_W-1:0] score_q, score_n;
  logic               best_clr, best_load, cmd_load;

  logic [LEN_W-1:0]   s_base_q, s_cnt_q, c_tlen_q;
  logic               first_q, last_q;
  logic [LEN_W-1:0]   cnt_n;

  always_comb begin
    state_n   = state;
    rem_n     = rem_q;
    base_n    = base_q;
    idx_n     = idx_q;
    t_len_n   = t_len_q;
    err_n     = err_q;
    valid_n   = valid_q;
    score_n   = score_q;
    best_clr  = 1'b0;
    best_load = 1'b0;
    cmd_load  = 1'b0;

    // Abort wins over ready/done arriving in the same cycle.
    if ((state != S_IDLE) && i_abort) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            rem_n    = i_s_len;
            base_n   = '0;
            idx_n    = '0;
            t_len_n  = i_t_len;
            valid_n  = 1'b0;
            best_clr = 1'b1;
            err_n    = (i_s_len == '0) || (i_t_len == '0);
            if (err_n) begin
              state_n = S_DONE;
            end else begin
              state_n  = S_ISSUE;
              cmd_load = 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (cmd.cmd_ready) state_n = S_RUN;
        end
        S_RUN: begin
          if (cmd.pass_done) begin
            score_n = cmd.pass_score;
            state_n = S_ACC;
          end
        end
        S_ACC: begin
          best_load = 1'b1;
          rem_n     = rem_q - s_cnt_q;
          base_n    = base_q + BASE_STEP;
          idx_n     = idx_q + 1'b1;
          if (rem_n == '0) begin
            state_n = S_DONE;
          end else begin
            state_n  = S_ISSUE;
            cmd_load = 1'b1;
          end
        end
        S_DONE: begin
          valid_n = 1'b1;
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end

    cnt_n = (rem_n > SEG_MAX) ? SEG_MAX : rem_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rem_q    <= '0;
      base_q   <= '0;
      idx_q    <= '0;
      t_len_q  <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      score_q  <= '0;
      s_base_q <= '0;
      s_cnt_q  <= '0;
      c_tlen_q <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state   <= state_n;
      rem_q   <= rem_n;
      base_q  <= base_n;
      idx_q   <= idx_n;
      t_len_q <= t_len_n;
      err_q   <= err_n;
      valid_q <= valid_n;
      score_q <= score_n;
      // Command fields are captured on entry to ISSUE so they hold under backpressure.
      if (cmd_load) begin
        s_base_q <= base_n[LEN_W-1:0];
        s_cnt_q  <= cnt_n;
        c_tlen_q <= t_len_n;
        first_q  <= (idx_n == '0);
        last_q   <= (rem_n <= SEG_MAX);
      end
    end
  end

  sw_score_max_reg #(.W(SCORE_W)) u_best (
    .clk  (clk),
    .rst  (rst),
    .clr  (best_clr),
    .load (best_load),
    .d    (score_q),
    .q    (o_best_score)
  );

  assign o_busy       = (state != S_IDLE);
  assign o_done       = (state == S_DONE);
  assign o_err        = (state == S_DONE) && err_q;
  assign o_best_valid = valid_q;
  assign o_pass_idx   = idx_q;

  assign cmd.cmd_valid  = (state == S_ISSUE);
  assign cmd.cmd_s_base = s_base_q;
  assign cmd.cmd_s_cnt  = s_cnt_q;
  assign cmd.cmd_t_len  = c_tlen_q;
  assign cmd.cmd_first  = first_q;
  assign cmd.cmd_last   = last_q;

endmodule

// File: tb/tb_sw_pass_scheduler.sv
// Directed bench for sw_pass_scheduler with an expected-command / expected-best scoreboard.
module tb_sw_pass_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic        i_abort;
  logic [15:0] i_s_len;
  logic [15:0] i_t_len;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [15:0] o_best_score;
  logic        o_best_valid;
  logic [15:0] o_pass_idx;

  sw_pass_scheduler_if #(.LEN_W(16), .SCORE_W(16)) bus ();

  sw_pass_scheduler #(.PE_N(64), .LEN_W(16), .SCORE_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_s_len      (i_s_len),
    .i_t_len      (i_t_len),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_best_score (o_best_score),
    .o_best_valid (o_best_valid),
    .o_pass_idx   (o_pass_idx),
    .cmd          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int base;
    int cnt;
    int tlen;
    int first;
    int last;
    int idx;
  } exp_cmd_t;

  exp_cmd_t    cmd_q[$];
  int          best_q[$];
  int          scores[4];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected commands derived from segment arithmetic: pass p covers S[p*64 .. ].
  task automatic plan(input int s_len, input int t_len);
    int np;
    int best;
    exp_cmd_t e;
    np   = (s_len + 63) / 64;
    best = 0;
    for (int p = 0; p < np; p++) begin
      e.base  = p * 64;
      e.cnt   = (p == np - 1) ? (s_len - p * 64) : 64;
      e.tlen  = t_len;
      e.first = (p == 0) ? 1 : 0;
      e.last  = (p == np - 1) ? 1 : 0;
      e.idx   = p;
      cmd_q.push_back(e);
      if (scores[p] > best) best = scores[p];
    end
    best_q.push_back(best);
  endtask

  task automatic start_run(input int s_len, input int t_len);
    i_s_len = 16'(s_len);
    i_t_len = 16'(t_len);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic issue(input int delay);
    exp_cmd_t e;
    chk("cmd_q_nonempty", (cmd_q.size() != 0), 1);
    if (cmd_q.size() == 0) return;
    e = cmd_q.pop_front();
    for (int k = 0; k <= delay; k++) begin
      if (k == delay) bus.cmd_ready = 1'b1;
      chk("cmd_valid", bus.cmd_valid, 1);
      chk("cmd_s_base", bus.cmd_s_base, e.base);
      chk("cmd_s_cnt", bus.cmd_s_cnt, e.cnt);
      chk("cmd_t_len", bus.cmd_t_len, e.tlen);
      chk("cmd_first", bus.cmd_first, e.first);
      chk("cmd_last", bus.cmd_last, e.last);
      chk("pass_idx", o_pass_idx, e.idx);
      chk("busy_issue", o_busy, 1);
      step();
    end
    bus.cmd_ready = 1'b0;
    chk("cmd_valid_after_xfer", bus.cmd_valid, 0);
  endtask

  task automatic finish_pass(input int score);
    step();
    i_start = 1'b1;
    i_s_len = 16'd5;
    i_t_len = 16'd5;
    step();
    i_start = 1'b0;
    chk("cmd_valid_in_run", bus.cmd_valid, 0);
    chk("busy_in_run", o_busy, 1);
    bus.pass_done  = 1'b1;
    bus.pass_score = 16'(score);
    step();
    bus.pass_done  = 1'b0;
    bus.pass_score = '0;
    step();
  endtask

  task automatic check_done(input int exp_err);
    int b;
    chk("best_q_nonempty", (best_q.size() != 0), 1);
    b = (best_q.size() != 0) ? best_q.pop_front() : 0;
    chk("done_pulse", o_done, 1);
    chk("err_pulse", o_err, exp_err);
    chk("busy_in_done", o_busy, 1);
    chk("cmd_valid_in_done", bus.cmd_valid, 0);
    chk("best_score_done", o_best_score, b);
    step();
    chk("done_one_cycle", o_done, 0);
    chk("err_one_cycle", o_err, 0);
    chk("busy_after_done", o_busy, 0);
    chk("best_valid", o_best_valid, 1);
    chk("best_score_held", o_best_score, b);
  endtask

  task automatic run_job(input int s_len, input int t_len, input int delay);
    int np;
    np = (s_len + 63) / 64;
    plan(s_len, t_len);
    start_run(s_len, t_len);
    for (int p = 0; p < np; p++) begin
      issue((p == 0) ? delay : 0);
      finish_pass(scores[p]);
    end
    check_done(0);
  endtask

  initial begin
    rst            = 1'b1;
    i_start        = 1'b0;
    i_abort        = 1'b0;
    i_s_len        = '0;
    i_t_len        = '0;
    bus.cmd_ready  = 1'b0;
    bus.pass_done  = 1'b0;
    bus.pass_score = '0;
    repeat (3) step();

    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_best", o_best_score, 0);
    chk("rst_best_valid", o_best_valid, 0);
    chk("rst_pass_idx", o_pass_idx, 0);
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    rst = 1'b0;
    step();

    // Stray completion while idle.
    bus.pass_done  = 1'b1;
    bus.pass_score = 16'd77;
    step();
    bus.pass_done  = 1'b0;
    step();
    chk("idle_done_ignored_busy", o_busy, 0);
    chk("idle_done_ignored_done", o_done, 0);
    chk("idle_done_ignored_best", o_best_score, 0);

    scores = '{12, 0, 0, 0};
    run_job(64, 10, 0);

    scores = '{5, 9, 7, 0};
    run_job(130, 20, 0);

    scores = '{4, 11, 0, 0};
    run_job(100, 7, 4);

    // Zero-length query.
    scores = '{0, 0, 0, 0};
    plan(0, 8);
    start_run(0, 8);
    check_done(1);

    // Abort during pass 1 of a 4-pass run, colliding with pass_done.
    scores = '{3, 50, 0, 0};
    plan(200, 30);
    start_run(200, 30);
    issue(0);
    finish_pass(scores[0]);
    issue(0);
    step();
    i_abort        = 1'b1;
    bus.pass_done  = 1'b1;
    bus.pass_score = 16'd99;
    step();
    i_abort        = 1'b0;
    bus.pass_done  = 1'b0;
    bus.pass_score = '0;
    chk("abort_busy", o_busy, 0);
    chk("abort_no_done", o_done, 0);
    chk("abort_cmd_valid", bus.cmd_valid, 0);
    chk("abort_best_valid", o_best_valid, 0);
    step();
    bus.pass_done  = 1'b1;
    bus.pass_score = 16'd200;
    step();
    bus.pass_done  = 1'b0;
    bus.pass_score = '0;
    step();
    chk("stray_done_busy", o_busy, 0);
    chk("stray_done_no_done", o_done, 0);
    chk("stray_done_best_valid", o_best_valid, 0);
    cmd_q.delete();
    best_q.delete();

    scores = '{21, 0, 0, 0};
    run_job(64, 12, 0);

    // Reset in the middle of a run.
    scores = '{5, 9, 7, 0};
    start_run(130, 20);
    plan(130, 20);
    issue(0);
    finish_pass(scores[0]);
    issue(0);
    rst = 1'b1;
    step();
    chk("midrst_busy", o_busy, 0);
    chk("midrst_done", o_done, 0);
    chk("midrst_best", o_best_score, 0);
    chk("midrst_pass_idx", o_pass_idx, 0);
    chk("midrst_cmd_valid", bus.cmd_valid, 0);
    chk("midrst_cmd_s_cnt", bus.cmd_s_cnt, 0);
    chk("midrst_cmd_s_base", bus.cmd_s_base, 0);
    rst = 1'b0;
    cmd_q.delete();
    best_q.delete();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
